// File: rtl/pwm_capture.sv
// PWM receiver: synchronises an asynchronous PWM input and measures period and high time
// in ck cycles, publishing each completed rising-edge-to-rising-edge measurement.
module pwm_capture #(
   parameter int unsigned CNT_W = 16
) (
   input  logic             ck,
   input  logic             rst,
   input  logic             pwm_in,
   output logic [CNT_W-1:0] period,
   output logic [CNT_W-1:0] high_time,
   output logic             meas_valid,
   output logic             timeout,
   output logic             busy
);

   localparam logic [1:0] StIdle  = 2'd0;
   localparam logic [1:0] StArmed = 2'd1;
   localparam logic [1:0] StHigh  = 2'd2;
   localparam logic [1:0] StLow   = 2'd3;

   localparam logic [CNT_W-1:0] CntMax = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);

   logic             s1_q, s_q, sd_q;
   logic [1:0]       fill_q;
   logic [1:0]       state_q, state_d;
   logic [CNT_W-1:0] pcnt_q, pcnt_d;
   logic [CNT_W-1:0] hcnt_q, hcnt_d;
   logic [CNT_W-1:0] period_q, period_d;
   logic [CNT_W-1:0] high_q, high_d;
   logic             valid_q, valid_d;
   logic             timeout_q, timeout_d;
   logic             busy_q, busy_d;
   logic             rise, fall, sat;

   assign rise = s_q & ~sd_q;
   assign fall = ~s_q & sd_q;
   assign sat  = (pcnt_q == CntMax);

   always_comb begin
      state_d   = state_q;
      pcnt_d    = pcnt_q;
      hcnt_d    = hcnt_q;
      period_d  = period_q;
      high_d    = high_q;
      valid_d   = 1'b0;
      timeout_d = 1'b0;
      case (state_q)
         // Until the synchroniser holds real samples, s reflects reset, not the pin.
         StIdle: begin
            if (fill_q[1] && !s_q) state_d = StArmed;
         end
         StArmed: begin
            if (rise) begin
               state_d = StHigh;
               pcnt_d  = CntOne;
               hcnt_d  = CntOne;
            end
         end
         StHigh: begin
            if (sat) begin
               state_d   = StIdle;
               timeout_d = 1'b1;
               pcnt_d    = '0;
               hcnt_d    = '0;
            end else begin
               pcnt_d = pcnt_q + CntOne;
               if (fall) state_d = StLow;
               else      hcnt_d  = hcnt_q + CntOne;
            end
         end
         StLow: begin
            // A closing rise wins over saturation on the same cycle.
            if (rise) begin
               period_d = pcnt_q;
               high_d   = hcnt_q;
               valid_d  = 1'b1;
               state_d  = StHigh;
               pcnt_d   = CntOne;
               hcnt_d   = CntOne;
            end else if (sat) begin
               state_d   = StIdle;
               timeout_d = 1'b1;
               pcnt_d    = '0;
               hcnt_d    = '0;
            end else begin
               pcnt_d = pcnt_q + CntOne;
            end
         end
         default: state_d = StIdle;
      endcase
      busy_d = (state_d == StHigh) || (state_d == StLow);
   end

   always_ff @(posedge ck or posedge rst) begin
      if (rst) begin
         s1_q      <= 1'b0;
         s_q       <= 1'b0;
         sd_q      <= 1'b0;
         fill_q    <= 2'b00;
         state_q   <= StIdle;
         pcnt_q    <= '0;
         hcnt_q    <= '0;
         period_q  <= '0;
         high_q    <= '0;
         valid_q   <= 1'b0;
         timeout_q <= 1'b0;
         busy_q    <= 1'b0;
      end else begin
         s1_q      <= pwm_in;
         s_q       <= s1_q;
         sd_q      <= s_q;
         fill_q    <= {fill_q[0], 1'b1};
         state_q   <= state_d;
         pcnt_q    <= pcnt_d;
         hcnt_q    <= hcnt_d;
         period_q  <= period_d;
         high_q    <= high_d;
         valid_q   <= valid_d;
         timeout_q <= timeout_d;
         busy_q    <= busy_d;
      end
   end

   assign period     = period_q;
   assign high_time  = high_q;
   assign meas_valid = valid_q;
   assign timeout    = timeout_q;
   assign busy       = busy_q;

endmodule

// File: tb/tb_pwm_capture.sv
// Randomised bench for pwm_capture: a segment-level model derives expected results from the
// sampled input waveform (rise/fall indices), checked every cycle with a two-sample latency.
module tb_pwm_capture;

   localparam int unsigned CNT_W = 8;
   localparam int MAX = (1 << CNT_W) - 1;

   logic             ck = 1'b0;
   logic             rst = 1'b1;
   logic             pwm_in = 1'b1;
   logic [CNT_W-1:0] period, high_time;
   logic             meas_valid, timeout, busy;

   pwm_capture #(.CNT_W(CNT_W)) dut (
      .ck        (ck),
      .rst       (rst),
      .pwm_in    (pwm_in),
      .period    (period),
      .high_time (high_time),
      .meas_valid(meas_valid),
      .timeout   (timeout),
      .busy      (busy)
   );

   always #5 ck = ~ck;

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s at %0t: got %0d, expected %0d", tag, $time, obs, exp);
      end
   endtask

   // Model state, in terms of sample indices of pwm_in since the last reset.
   typedef struct {
      logic v;
      logic to;
      logic b;
      int   per;
      int   hi;
   } exp_t;

   exp_t q[$];
   int   j, r, f, rearm_at, m_per, m_hi;
   logic prev, meas;

   task automatic model_reset();
      exp_t z;
      z = '{v: 1'b0, to: 1'b0, b: 1'b0, per: 0, hi: 0};
      q.delete();
      q.push_back(z);
      q.push_back(z);
      j = 0; r = 0; f = 0; rearm_at = 0; m_per = 0; m_hi = 0;
      prev = 1'b0; meas = 1'b0;
   endtask

   task automatic model_step(input logic v);
      exp_t e;
      logic rising, falling;
      rising  = (j >= 1) && !prev && v;
      falling = (j >= 1) && prev && !v;
      e.v  = 1'b0;
      e.to = 1'b0;
      if (meas) begin
         if (rising) begin
            m_per = j - r;
            m_hi  = f - r;
            e.v   = 1'b1;
            r     = j;
         end else begin
            if (falling) f = j;
            if (j - r == MAX) begin
               e.to     = 1'b1;
               meas     = 1'b0;
               rearm_at = j + 2;
            end
         end
      end else if (rising && j >= rearm_at) begin
         meas = 1'b1;
         r    = j;
      end
      e.b   = meas;
      e.per = m_per;
      e.hi  = m_hi;
      q.push_back(e);
      prev = v;
      j++;
   endtask

   // Called at a negedge; returns at the following negedge.
   task automatic step(input logic v);
      exp_t e;
      pwm_in = v;
      @(posedge ck);
      #1;
      model_step(v);
      e = q.pop_front();
      check("meas_valid", 32'(meas_valid), 32'(e.v));
      check("timeout", 32'(timeout), 32'(e.to));
      check("busy", 32'(busy), 32'(e.b));
      check("period", 32'(period), e.per);
      check("high_time", 32'(high_time), e.hi);
      @(negedge ck);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      #1;
      check("rst_period", 32'(period), 0);
      check("rst_high_time", 32'(high_time), 0);
      check("rst_meas_valid", 32'(meas_valid), 0);
      check("rst_timeout", 32'(timeout), 0);
      check("rst_busy", 32'(busy), 0);
      @(posedge ck);
      @(negedge ck);
      rst = 1'b0;
      model_reset();
   endtask

   task automatic pulses(input int hi, input int lo, input int n);
      for (int k = 0; k < n; k++) begin
         repeat (hi) step(1'b1);
         repeat (lo) step(1'b0);
      end
   endtask

   initial begin
      int hi, lo;
      @(negedge ck);
      // Input already high across reset: must not arm until it drops.
      pwm_in = 1'b1;
      do_reset();
      repeat (300) step(1'b1);
      pulses(5, 5, 4);
      // Steady 3/7 then duty change to 8/2.
      pulses(3, 7, 6);
      pulses(8, 2, 4);
      // Single-cycle highs every 4 cycles.
      pulses(1, 3, 6);
      // One rise then held high: timeout.
      repeat (300) step(1'b1);
      repeat (5) step(1'b0);
      pulses(4, 6, 3);
      // Short high then held low: timeout from LOW.
      step(1'b1);
      step(1'b1);
      repeat (300) step(1'b0);
      pulses(2, 3, 3);
      // Reset mid-HIGH, then resume 2/4.
      pulses(2, 4, 3);
      step(1'b1);
      do_reset();
      pulses(2, 4, 5);
      // Randomised segments, including occasional saturating lows and highs.
      for (int k = 0; k < 60; k++) begin
         hi = $urandom_range(1, 20);
         lo = $urandom_range(1, 20);
         if ($urandom_range(0, 9) == 0) lo = $urandom_range(240, 300);
         if ($urandom_range(0, 14) == 0) hi = $urandom_range(240, 300);
         pulses(hi, lo, 1);
      end
      // Boundary: period exactly MAX publishes, MAX+1 times out.
      pulses(1, 10, 1);
      pulses(1, MAX - 1, 1);
      pulses(1, MAX, 1);
      pulses(3, 3, 3);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
